add_logic_unit: RTL and testbench
=================================

// Module: add_logic_unit
// PURPOSE
//   Registered datapath slice of the processor ALU: executes ADD, bitwise AND and bitwise OR
//   on two register operands, producing a destination value and NZCV status flags.
//   Sits between register-file read ports and write-back; one result per cycle, 1-cycle latency.
// PARAMETERS
//   WIDTH  16  operand/result width in bits (>= 2)
// PORTS
//   clk       in   1      system clock, rising edge
//   rst_n     in   1      asynchronous active-low reset
//   in_valid  in   1      operation request this cycle
//   op        in   2      2'b00 ADD, 2'b01 AND, 2'b10 OR, 2'b11 reserved (NOP)
//   reg1      in   WIDTH  operand A
//   reg2      in   WIDTH  operand B
//   dest_reg  out  WIDTH  registered result
//   flag      out  4      registered flags {N,Z,C,V}
//   out_valid out  1      dest_reg updated by the previous-cycle request
// BEHAVIOUR
//   - Reset (rst_n low, asynchronous): dest_reg=0, flag=4'b0000, out_valid=0; held while low.
//   - Release is synchronous to the next rising clk edge; no request is lost on deassertion.
//   - Latency 1: request sampled at edge k; dest_reg/flag/out_valid valid after edge k.
//   - No backpressure; one request per cycle, back-to-back accepted.
//   - out_valid <= in_valid & (op != 2'b11).
//   - ADD: {c,sum} = reg1 + reg2 in WIDTH+1 bits; dest_reg <= sum[WIDTH-1:0].
//       N = sum[WIDTH-1]; Z = (sum[WIDTH-1:0]==0); C = carry-out c;
//       V = (reg1[MSB]==reg2[MSB]) & (sum[MSB]!=reg1[MSB]). Wrap-around modulo 2^WIDTH.
//   - AND: dest_reg <= reg1 & reg2; flag unchanged.
//   - OR:  dest_reg <= reg1 | reg2; flag unchanged.
//   - op=2'b11, or in_valid=0: dest_reg and flag hold previous values; out_valid=0.
//   - Flags update only on a valid ADD; they persist across any number of AND/OR/NOP cycles.
//   - Reset asserted mid-stream discards the in-flight result; outputs go to reset values at once.
//   - No X propagation: all outputs defined from reset onward.
// CONFIGURATION
//   ADD_LOGIC_SAT_EN
//     defined:   ADD saturates as signed: on V=1, dest_reg <= reg1[MSB] ? {1'b1,{WIDTH-1{1'b0}}}
//                : {1'b0,{WIDTH-1{1'b1}}}; N/Z computed from the saturated value; C and V from
//                the unsaturated sum.
//     undefined: ADD wraps modulo 2^WIDTH as above. AND/OR identical in both builds.
// TESTING
//   1 Reset: rst_n=0 mid-cycle -> dest_reg=0, flag=0000, out_valid=0 immediately.
//   2 ADD 16'h0003+16'h0004 -> dest_reg=16'h0007, flag=0000, out_valid=1 next cycle;
//     ADD 16'hFFFF+16'h0001 -> 16'h0000, flag=0110 (Z,C).
//   3 ADD 16'h7FFF+16'h0001 -> 16'h8000, flag=1001 (N,V); with ADD_LOGIC_SAT_EN -> 16'h7FFF, flag=0001.
//   4 AND 16'hF0F0&16'h3C3C -> 16'h3030; OR same operands -> 16'hFCFC; flag keeps value from last ADD.
//   5 op=2'b11 or in_valid=0 after result 16'h1234 -> dest_reg stays 16'h1234, out_valid=0.
//   6 Back-to-back ADD, AND, OR on consecutive cycles -> three consecutive correct results, out_valid=1 each.

Source files
------------

// File: rtl/add_logic_unit_if.sv
// Request/result bundle for add_logic_unit.
//   master : drives in_valid, op, reg1, reg2; observes dest_reg, flag, out_valid
//   slave  : the ALU slice; observes the request, drives the registered result
// Signals:
//   in_valid  1      operation request this cycle
//   op        2      00 ADD, 01 AND, 10 OR, 11 reserved (NOP)
//   reg1/reg2 WIDTH  operands A/B
//   dest_reg  WIDTH  registered result
//   flag      4      registered flags {N,Z,C,V}
//   out_valid 1      dest_reg updated by the previous-cycle request
interface add_logic_unit_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic [1:0]       op;
  logic [WIDTH-1:0] reg1;
  logic [WIDTH-1:0] reg2;
  logic [WIDTH-1:0] dest_reg;
  logic [3:0]       flag;
  logic             out_valid;

  modport master (
    output in_valid, op, reg1, reg2,
    input  dest_reg, flag, out_valid
  );

  modport slave (
    input  in_valid, op, reg1, reg2,
    output dest_reg, flag, out_valid
  );
endinterface

// File: rtl/add_logic_unit.sv
// add_logic_unit: registered ALU slice executing ADD, AND and OR with NZCV flags.
// One request per cycle, no backpressure, 1-cycle latency.
// Ports:
//   clk    in  system clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   bus    add_logic_unit_if.slave (in_valid, op, reg1, reg2 -> dest_reg, flag, out_valid)
// Build option:
//   ADD_LOGIC_SAT_EN  defined: ADD saturates as signed on overflow (N/Z from the saturated
//                     value, C/V from the raw sum). Undefined: ADD wraps modulo 2^WIDTH.
module add_logic_unit #(
  parameter int unsigned WIDTH = 16
) (
  input logic             clk,
  input logic             rst_n,
  add_logic_unit_if.slave bus
);

  localparam logic [1:0] OpAdd = 2'b00;
  localparam logic [1:0] OpAnd = 2'b01;
  localparam logic [1:0] OpOr  = 2'b10;

  logic [WIDTH-1:0] dest_q, dest_d;
  logic [3:0]       flag_q, flag_d;
  logic             valid_q, valid_d;

  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] add_res;
  logic             carry;
  logic             ovf;

  always_comb begin
    sum_ext = {1'b0, bus.reg1} + {1'b0, bus.reg2};
    sum     = sum_ext[WIDTH-1:0];
    carry   = sum_ext[WIDTH];
    // Signed overflow: like-signed operands yielding a differently-signed result.
    ovf     = (bus.reg1[WIDTH-1] == bus.reg2[WIDTH-1]) &&
              (sum[WIDTH-1] != bus.reg1[WIDTH-1]);
`ifdef ADD_LOGIC_SAT_EN
    if (ovf) begin
      add_res = bus.reg1[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      add_res = sum;
    end
`else
    add_res = sum;
`endif
  end

  always_comb begin
    dest_d  = dest_q;
    flag_d  = flag_q;
    valid_d = 1'b0;
    if (bus.in_valid) begin
      unique case (bus.op)
        OpAdd: begin
          dest_d  = add_res;
          flag_d  = {add_res[WIDTH-1], (add_res == '0), carry, ovf};
          valid_d = 1'b1;
        end
        OpAnd: begin
          dest_d  = bus.reg1 & bus.reg2;
          valid_d = 1'b1;
        end
        OpOr: begin
          dest_d  = bus.reg1 | bus.reg2;
          valid_d = 1'b1;
        end
        default: begin
          // Reserved op behaves as a NOP: hold result and flags.
          valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dest_q  <= '0;
      flag_q  <= 4'b0000;
      valid_q <= 1'b0;
    end else begin
      dest_q  <= dest_d;
      flag_q  <= flag_d;
      valid_q <= valid_d;
    end
  end

  assign bus.dest_reg  = dest_q;
  assign bus.flag      = flag_q;
  assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_add_logic_unit.sv
// Directed self-checking bench for add_logic_unit (WIDTH = 16).
module tb_add_logic_unit;

  localparam int unsigned WIDTH = 16;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  add_logic_unit_if #(.WIDTH(WIDTH)) bus ();

  add_logic_unit #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [15:0] exp_dest,
                           input logic [3:0] exp_flag, input logic exp_valid);
    check({tag, ".dest"},  32'(bus.dest_reg),  32'(exp_dest));
    check({tag, ".flag"},  32'(bus.flag),      32'(exp_flag));
    check({tag, ".valid"}, 32'(bus.out_valid), 32'(exp_valid));
  endtask

  // Drive one request at the falling edge, sample 1 ns after the following rising edge.
  task automatic do_op(input logic v, input logic [1:0] o, input logic [15:0] a,
                       input logic [15:0] b);
    @(negedge clk);
    bus.in_valid = v;
    bus.op       = o;
    bus.reg1     = a;
    bus.reg2     = b;
    @(posedge clk);
    #1;
  endtask

  logic [15:0] ovf_dest, neg_dest;
  logic [3:0]  ovf_flag, neg_flag;

  initial begin
    n_checks = 0;
    n_errors = 0;
`ifdef ADD_LOGIC_SAT_EN
    ovf_dest = 16'h7FFF; ovf_flag = 4'b0001;
    neg_dest = 16'h8000; neg_flag = 4'b1011;
`else
    ovf_dest = 16'h8000; ovf_flag = 4'b1001;
    neg_dest = 16'h0000; neg_flag = 4'b0111;
`endif
    bus.in_valid = 1'b1;
    bus.op       = 2'b00;
    bus.reg1     = 16'h1111;
    bus.reg2     = 16'h2222;
    rst_n        = 1'b0;

    // Reset held across an edge with a live request.
    @(posedge clk);
    #1;
    check_out("reset", 16'h0000, 4'b0000, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.in_valid = 1'b0;

    do_op(1'b1, 2'b00, 16'h0003, 16'h0004);
    check_out("add_3_4", 16'h0007, 4'b0000, 1'b1);
    do_op(1'b1, 2'b00, 16'hFFFF, 16'h0001);
    check_out("add_carry", 16'h0000, 4'b0110, 1'b1);
    do_op(1'b1, 2'b00, 16'h7FFF, 16'h0001);
    check_out("add_ovf", ovf_dest, ovf_flag, 1'b1);
    do_op(1'b1, 2'b01, 16'hF0F0, 16'h3C3C);
    check_out("and", 16'h3030, ovf_flag, 1'b1);
    do_op(1'b1, 2'b10, 16'hF0F0, 16'h3C3C);
    check_out("or", 16'hFCFC, ovf_flag, 1'b1);
    do_op(1'b1, 2'b00, 16'h8000, 16'h8000);
    check_out("add_neg_ovf", neg_dest, neg_flag, 1'b1);

    do_op(1'b1, 2'b00, 16'h1200, 16'h0034);
    check_out("add_1234", 16'h1234, 4'b0000, 1'b1);
    do_op(1'b1, 2'b11, 16'hFFFF, 16'hFFFF);
    check_out("nop_op11", 16'h1234, 4'b0000, 1'b0);
    do_op(1'b0, 2'b00, 16'h7FFF, 16'h0001);
    check_out("idle", 16'h1234, 4'b0000, 1'b0);

    // Back-to-back on consecutive cycles.
    do_op(1'b1, 2'b00, 16'h0001, 16'h0002);
    check_out("b2b_add", 16'h0003, 4'b0000, 1'b1);
    do_op(1'b1, 2'b01, 16'h00FF, 16'h0F0F);
    check_out("b2b_and", 16'h000F, 4'b0000, 1'b1);
    do_op(1'b1, 2'b10, 16'h00F0, 16'h0F00);
    check_out("b2b_or", 16'h0FF0, 4'b0000, 1'b1);

    // Mid-cycle reset discards the pending request and clears outputs at once.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op       = 2'b00;
    bus.reg1     = 16'h8000;
    bus.reg2     = 16'hFFFF;
    #2;
    rst_n = 1'b0;
    #1;
    check_out("reset_async", 16'h0000, 4'b0000, 1'b0);
    @(posedge clk);
    #1;
    check_out("reset_held", 16'h0000, 4'b0000, 1'b0);

    // Request present at deassertion is taken by the next edge.
    @(negedge clk);
    rst_n    = 1'b1;
    bus.reg1 = 16'h0005;
    bus.reg2 = 16'h0006;
    @(posedge clk);
    #1;
    check_out("after_release", 16'h000B, 4'b0000, 1'b1);

    bus.in_valid = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
